// File: rtl/hs_pkg.sv
// Shared definitions for the valid/ready stream source and its companion sink.
package hs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } hs_state_t;

  // Default nonzero seed for the gap LFSR.
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // Taps for x^16+x^14+x^13+x^11 in a shift-left Fibonacci register: bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Only the two low LFSR bits decide whether a beat may be issued (75% duty).
  localparam logic [15:0] LFSR_GAP_MASK = 16'h0003;

  // One Fibonacci step: shift left, XOR of tapped bits enters bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/hs_lfsr16.sv
// 16-bit Fibonacci LFSR with advance enable and synchronous seed reload.
module hs_lfsr16
  import hs_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load_seed,
  input  logic        i_advance,
  output logic [15:0] o_lfsr
);

  logic [15:0] r_lfsr;
  logic [15:0] w_base;

  // Reload takes priority; advancing on the reload edge steps from the seed.
  assign w_base = i_load_seed ? SEED : r_lfsr;

  // Register update: async reset to seed, otherwise load and/or advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= SEED;
    end else if (i_advance) begin
      r_lfsr <= lfsr_step(w_base);
    end else begin
      r_lfsr <= w_base;
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/hs_stream_source.sv
// Valid/ready burst transmitter with optional pseudo-random idle gaps.
module hs_stream_source
  import hs_pkg::*;
#(
  parameter int          DATA_W    = 16,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  beat_count,
  input  logic [DATA_W-1:0] start_value,
  input  logic              gap_en,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              ready_in,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sent_count
);

  hs_state_t         r_state;
  hs_state_t         w_state_n;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_sent;
  logic [CNT_W-1:0]  r_remaining;

  logic              w_accept;
  logic              w_nonempty;
  logic              w_xfer;
  logic              w_last;
  logic              w_issue;
  logic              w_lfsr_adv;
  logic [15:0]       w_lfsr;
  logic [15:0]       w_lfsr_view;

  assign w_accept   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_nonempty = (beat_count != '0);
  assign w_xfer     = r_valid && ready_in;
  assign w_last     = (r_remaining == CNT_W'(1));

  // On the launch edge the LFSR is being reloaded, so the gap decision uses the seed.
  assign w_lfsr_view = w_accept ? LFSR_SEED : w_lfsr;
  assign w_issue     = !gap_en || ((w_lfsr_view & LFSR_GAP_MASK) != 16'h0000);
  assign w_lfsr_adv  = (r_state == ST_RUN) || (w_accept && w_nonempty);

  hs_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk         (clk),
    .rst         (rst),
    .i_load_seed (w_accept),
    .i_advance   (w_lfsr_adv),
    .o_lfsr      (w_lfsr)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Next-state logic: launch from IDLE/DONE, finish on the last handshake.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_n = w_nonempty ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (w_xfer && w_last) begin
          w_state_n = ST_DONE;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // Beat issue, data increment and transfer counting; a pending beat is never retracted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_sent      <= '0;
      r_remaining <= '0;
    end else if (w_accept) begin
      r_remaining <= beat_count;
      r_data      <= start_value;
      r_sent      <= '0;
      r_valid     <= w_nonempty && w_issue;
    end else if (r_state == ST_RUN) begin
      if (w_xfer) begin
        r_sent      <= r_sent + CNT_W'(1);
        r_remaining <= r_remaining - CNT_W'(1);
        r_data      <= r_data + DATA_W'(1);
        r_valid     <= w_last ? 1'b0 : w_issue;
      end else if (!r_valid) begin
        r_valid     <= w_issue;
      end
    end
  end

  assign valid_out  = r_valid;
  assign data_out   = r_data;
  assign sent_count = r_sent;
  assign busy       = (r_state == ST_RUN);
  assign done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_hs_stream_source.sv
// Directed bench for hs_stream_source: throughput, stalls, gaps, wrap, reset, ignored start.
module tb_hs_stream_source;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] beat_count;
  logic [15:0] start_value;
  logic        gap_en;
  logic        valid_out;
  logic [15:0] data_out;
  logic        ready_in;
  logic        busy;
  logic        done;
  logic [15:0] sent_count;

  int n_vec = 0;
  int n_err = 0;

  hs_stream_source dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .beat_count  (beat_count),
    .start_value (start_value),
    .gap_en      (gap_en),
    .valid_out   (valid_out),
    .data_out    (data_out),
    .ready_in    (ready_in),
    .busy        (busy),
    .done        (done),
    .sent_count  (sent_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference LFSR step written from the polynomial taps 16,14,13,11.
  function automatic logic [15:0] ref_step(input logic [15:0] l);
    logic fb;
    fb = l[15] ^ l[13] ^ l[12] ^ l[10];
    return {l[14:0], fb};
  endfunction

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; beat_count = '0; start_value = '0;
    gap_en = 1'b0; ready_in = 1'b1;
    #2;
    n_vec++;
    if ({valid_out, busy, done, sent_count, data_out} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b busy=%b done=%b sent=%0d data=%h required all zero",
               valid_out, busy, done, sent_count, data_out);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
    n_vec++;
    if ({valid_out, busy, done} !== 3'b000) begin
      n_err++;
      $display("FAIL idle_after_reset: valid=%b busy=%b done=%b required 000", valid_out, busy, done);
    end
  endtask

  task automatic test_full_rate();
    start = 1'b1; beat_count = 16'd8; start_value = 16'd16; gap_en = 1'b0; ready_in = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (valid_out !== 1'b1 || data_out !== 16'(16 + i) || busy !== 1'b1) begin
        n_err++;
        $display("FAIL full_rate_beat%0d: valid=%b data=%h busy=%b required valid=1 data=%h busy=1",
                 i, valid_out, data_out, busy, 16'(16 + i));
      end
      tick();
    end
    n_vec++;
    if (done !== 1'b1 || valid_out !== 1'b0 || sent_count !== 16'd8 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL full_rate_end: done=%b valid=%b sent=%0d busy=%b required done=1 valid=0 sent=8 busy=0",
               done, valid_out, sent_count, busy);
    end
  endtask

  task automatic test_backpressure();
    start = 1'b1; beat_count = 16'd4; start_value = 16'd16; gap_en = 1'b0; ready_in = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (valid_out !== 1'b1 || data_out !== 16'd16 || sent_count !== 16'd0) begin
        n_err++;
        $display("FAIL stall_cycle%0d: valid=%b data=%h sent=%0d required valid=1 data=0010 sent=0",
                 i, valid_out, data_out, sent_count);
      end
      tick();
    end
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (valid_out !== 1'b1 || data_out !== 16'(16 + i)) begin
        n_err++;
        $display("FAIL after_stall_beat%0d: valid=%b data=%h required valid=1 data=%h",
                 i, valid_out, data_out, 16'(16 + i));
      end
      tick();
    end
    n_vec++;
    if (done !== 1'b1 || sent_count !== 16'd4 || valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL stall_end: done=%b sent=%0d valid=%b required done=1 sent=4 valid=0",
               done, sent_count, valid_out);
    end
  endtask

  task automatic test_gaps();
    logic [15:0] lfsr;
    logic        exp_v;
    int          sent;
    int          cyc;
    int          bubbles;
    lfsr = 16'hACE1;
    sent = 0;
    cyc = 0;
    bubbles = 0;
    start = 1'b1; beat_count = 16'd64; start_value = 16'd0; gap_en = 1'b1; ready_in = 1'b1;
    exp_v = (lfsr[1:0] != 2'b00);
    lfsr = ref_step(lfsr);
    tick();
    start = 1'b0;
    while (sent < 64 && cyc < 400) begin
      n_vec++;
      if (valid_out !== exp_v) begin
        n_err++;
        $display("FAIL gap_valid_cyc%0d: valid=%b required %b", cyc, valid_out, exp_v);
      end
      if (valid_out === 1'b0) bubbles++;
      if (exp_v) begin
        n_vec++;
        if (data_out !== 16'(sent)) begin
          n_err++;
          $display("FAIL gap_data_beat%0d: data=%h required %h", sent, data_out, 16'(sent));
        end
        sent++;
      end
      if (sent < 64) begin
        exp_v = (lfsr[1:0] != 2'b00);
        lfsr = ref_step(lfsr);
      end
      tick();
      cyc++;
    end
    n_vec++;
    if (sent != 64) begin
      n_err++;
      $display("FAIL gap_timeout: beats=%0d required 64 within 400 cycles", sent);
    end
    n_vec++;
    if (bubbles == 0) begin
      n_err++;
      $display("FAIL gap_bubbles: bubbles=%0d required nonzero", bubbles);
    end
    n_vec++;
    if (done !== 1'b1 || sent_count !== 16'd64 || valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL gap_end: done=%b sent=%0d valid=%b required done=1 sent=64 valid=0",
               done, sent_count, valid_out);
    end
    gap_en = 1'b0;
  endtask

  task automatic test_wrap_and_empty();
    logic [15:0] exp_d [4];
    exp_d[0] = 16'hFFFE; exp_d[1] = 16'hFFFF; exp_d[2] = 16'h0000; exp_d[3] = 16'h0001;
    start = 1'b1; beat_count = 16'd4; start_value = 16'hFFFE; ready_in = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (valid_out !== 1'b1 || data_out !== exp_d[i]) begin
        n_err++;
        $display("FAIL wrap_beat%0d: valid=%b data=%h required valid=1 data=%h",
                 i, valid_out, data_out, exp_d[i]);
      end
      tick();
    end
    n_vec++;
    if (done !== 1'b1 || sent_count !== 16'd4) begin
      n_err++;
      $display("FAIL wrap_end: done=%b sent=%0d required done=1 sent=4", done, sent_count);
    end
    start = 1'b1; beat_count = 16'd0; start_value = 16'h1234;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (done !== 1'b1 || busy !== 1'b0 || valid_out !== 1'b0 || sent_count !== 16'd0) begin
        n_err++;
        $display("FAIL empty_burst_cyc%0d: done=%b busy=%b valid=%b sent=%0d required done=1 busy=0 valid=0 sent=0",
                 i, done, busy, valid_out, sent_count);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_burst();
    start = 1'b1; beat_count = 16'd10; start_value = 16'd200; ready_in = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (valid_out !== 1'b1 || data_out !== 16'(200 + i)) begin
        n_err++;
        $display("FAIL pre_reset_beat%0d: valid=%b data=%h required valid=1 data=%h",
                 i, valid_out, data_out, 16'(200 + i));
      end
      tick();
    end
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if (valid_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sent_count !== 16'd0) begin
      n_err++;
      $display("FAIL async_reset: valid=%b busy=%b done=%b sent=%0d required all zero",
               valid_out, busy, done, sent_count);
    end
    #1;
    rst = 1'b1;
    tick();
    n_vec++;
    if (valid_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: valid=%b busy=%b done=%b required 000", valid_out, busy, done);
    end
    start = 1'b1; beat_count = 16'd3; start_value = 16'd100;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (valid_out !== 1'b1 || data_out !== 16'(100 + i)) begin
        n_err++;
        $display("FAIL restart_beat%0d: valid=%b data=%h required valid=1 data=%h",
                 i, valid_out, data_out, 16'(100 + i));
      end
      tick();
    end
    n_vec++;
    if (done !== 1'b1 || sent_count !== 16'd3) begin
      n_err++;
      $display("FAIL restart_end: done=%b sent=%0d required done=1 sent=3", done, sent_count);
    end
  endtask

  task automatic test_start_in_run();
    start = 1'b1; beat_count = 16'd5; start_value = 16'd40; ready_in = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 1 || i == 2) begin
        start = 1'b1; beat_count = 16'd2; start_value = 16'd7;
      end else begin
        start = 1'b0;
      end
      n_vec++;
      if (valid_out !== 1'b1 || data_out !== 16'(40 + i)) begin
        n_err++;
        $display("FAIL run_start_beat%0d: valid=%b data=%h required valid=1 data=%h",
                 i, valid_out, data_out, 16'(40 + i));
      end
      tick();
    end
    start = 1'b0;
    n_vec++;
    if (done !== 1'b1 || sent_count !== 16'd5 || valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL run_start_end: done=%b sent=%0d valid=%b required done=1 sent=5 valid=0",
               done, sent_count, valid_out);
    end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_backpressure();
    test_gaps();
    test_wrap_and_empty();
    test_reset_mid_burst();
    test_start_in_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
